// File: rtl/accel_spi_responder.sv
// SPI mode-0 register responder for a 3-axis accelerometer.
// Optional ACCEL_RESP_SOFT_RESET_EN: writing 0x52 to 0x1F restores 0x20-0x2E.
module accel_spi_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] REVID       = 8'h01
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        sclk_i,
  input  logic        ss_i,
  input  logic        mosi_i,
  output logic        miso_o,
  input  logic [11:0] accel_x_i,
  input  logic [11:0] accel_y_i,
  input  logic [11:0] accel_z_i,
  output logic        busy_o,
  output logic        cmd_err_o,
  output logic        wr_pulse_o,
  output logic [7:0]  wr_addr_o,
  output logic [7:0]  wr_data_o
);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DATA, IGNORE
  } state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic sclk_prev_q;
  logic ss_prev_q;
  logic armed_q;

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall;
  logic ss_rise, ss_fall;

  // ss flops clear to 0 so a reset taken with ss low
  // never fakes a falling edge afterwards.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
      armed_q     <= armed_q | ss_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ss_rise   = ss_s & ~ss_prev_q;
  assign ss_fall   = ~ss_s & ss_prev_q;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [7:0]  shift_q;
  logic [7:0]  ptr_q;
  logic        rd_q;
  logic [7:0]  tx_q;
  logic        miso_q;
  logic        busy_q;
  logic        cmd_err_q;
  logic        wr_pulse_q;
  logic [7:0]  wr_addr_q;
  logic [7:0]  wr_data_q;
  logic [11:0] shx_q, shy_q, shz_q;
  logic [7:0]  rw_q [15];

  logic [7:0] shift_d;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       byte_done;
  logic       wr_ok;
  logic       soft_rst;

  assign shift_d   = {shift_q[6:0], mosi_s};
  assign byte_done = sclk_rise && (cnt_q == 3'd7);
  assign rd_addr   = (state_q == ADDR) ? shift_d
                                       : ptr_q + 8'd1;
  assign wr_ok     = (ptr_q[7:4] == 4'h2) &&
                     (ptr_q[3:0] != 4'hF);

`ifdef ACCEL_RESP_SOFT_RESET_EN
  assign soft_rst = (ptr_q == 8'h1F) && (shift_d == 8'h52);
`else
  assign soft_rst = 1'b0;
`endif

  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      8'h00: rd_data = 8'hAD;
      8'h01: rd_data = 8'h1D;
      8'h02: rd_data = 8'hF2;
      8'h03: rd_data = REVID;
      8'h08: rd_data = shx_q[11:4];
      8'h09: rd_data = shy_q[11:4];
      8'h0A: rd_data = shz_q[11:4];
      8'h0B: rd_data = 8'h01;
      8'h0E: rd_data = shx_q[7:0];
      8'h0F: rd_data = {{4{shx_q[11]}}, shx_q[11:8]};
      8'h10: rd_data = shy_q[7:0];
      8'h11: rd_data = {{4{shy_q[11]}}, shy_q[11:8]};
      8'h12: rd_data = shz_q[7:0];
      8'h13: rd_data = {{4{shz_q[11]}}, shz_q[11:8]};
      default: begin
        if (rd_addr[7:4] == 4'h2 && rd_addr[3:0] != 4'hF)
          rd_data = rw_q[rd_addr[3:0]];
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      rd_q       <= 1'b0;
      tx_q       <= '0;
      miso_q     <= 1'b0;
      busy_q     <= 1'b0;
      cmd_err_q  <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      shx_q      <= '0;
      shy_q      <= '0;
      shz_q      <= '0;
      for (int i = 0; i < 15; i++)
        rw_q[i] <= (i == 12) ? 8'h13 : 8'h00;
    end else begin
      cmd_err_q  <= 1'b0;
      wr_pulse_q <= 1'b0;
      busy_q     <= armed_q & ~ss_s;
      if (ss_rise) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        miso_q  <= 1'b0;
      end else if (ss_fall) begin
        state_q <= CMD;
        cnt_q   <= '0;
        miso_q  <= 1'b0;
        shx_q   <= accel_x_i;
        shy_q   <= accel_y_i;
        shz_q   <= accel_z_i;
      end else if (state_q inside {CMD, ADDR, DATA}) begin
        if (sclk_rise) begin
          shift_q <= shift_d;
          cnt_q   <= cnt_q + 3'd1;
        end
        if (byte_done) begin
          case (state_q)
            CMD: begin
              if (shift_d == 8'h0A || shift_d == 8'h0B) begin
                rd_q    <= shift_d[0];
                state_q <= ADDR;
              end else begin
                state_q   <= IGNORE;
                cmd_err_q <= 1'b1;
              end
            end
            ADDR: begin
              ptr_q   <= shift_d;
              state_q <= DATA;
              if (rd_q) begin
                tx_q   <= rd_data;
                miso_q <= rd_data[7];
              end
            end
            DATA: begin
              ptr_q <= ptr_q + 8'd1;
              if (rd_q) begin
                tx_q   <= rd_data;
                miso_q <= rd_data[7];
              end else begin
                wr_pulse_q <= 1'b1;
                wr_addr_q  <= ptr_q;
                wr_data_q  <= shift_d;
                if (soft_rst) begin
                  for (int i = 0; i < 15; i++)
                    rw_q[i] <= (i == 12) ? 8'h13 : 8'h00;
                end else if (wr_ok) begin
                  rw_q[ptr_q[3:0]] <= shift_d;
                end
              end
            end
            default: ;
          endcase
        end else if (sclk_fall && state_q == DATA &&
                     rd_q && cnt_q != 3'd0) begin
          // the fall right after a byte load must not shift
          tx_q   <= {tx_q[6:0], 1'b0};
          miso_q <= tx_q[6];
        end
      end
    end
  end

  assign miso_o     = miso_q;
  assign busy_o     = busy_q;
  assign cmd_err_o  = cmd_err_q;
  assign wr_pulse_o = wr_pulse_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;

endmodule

// File: tb/tb_accel_spi_responder.sv
// Randomized bench for accel_spi_responder against a
// register-map level reference model.
module tb_accel_spi_responder;

  typedef logic [7:0]  u8;
  typedef logic [15:0] u16;

  localparam int HALF = 60;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        sclk_i;
  logic        ss_i;
  logic        mosi_i;
  logic        miso_o;
  logic [11:0] accel_x_i;
  logic [11:0] accel_y_i;
  logic [11:0] accel_z_i;
  logic        busy_o;
  logic        cmd_err_o;
  logic        wr_pulse_o;
  logic [7:0]  wr_addr_o;
  logic [7:0]  wr_data_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  accel_spi_responder dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .sclk_i    (sclk_i),
    .ss_i      (ss_i),
    .mosi_i    (mosi_i),
    .miso_o    (miso_o),
    .accel_x_i (accel_x_i),
    .accel_y_i (accel_y_i),
    .accel_z_i (accel_z_i),
    .busy_o    (busy_o),
    .cmd_err_o (cmd_err_o),
    .wr_pulse_o(wr_pulse_o),
    .wr_addr_o (wr_addr_o),
    .wr_data_o (wr_data_o)
  );

  u16 wr_obs[$];
  int ce_obs;

  always @(negedge clk) begin
    if (wr_pulse_o) wr_obs.push_back({wr_addr_o, wr_data_o});
    if (cmd_err_o) ce_obs++;
  end

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: register map as plain data
  u8   m_rw [15];
  int  m_x, m_y, m_z;

  function automatic void m_reset();
    for (int i = 0; i < 15; i++) m_rw[i] = 8'h00;
    m_rw[12] = 8'h13;
  endfunction

  function automatic u8 m_read(u8 a);
    if (a >= 8'h20 && a <= 8'h2E) return m_rw[a - 8'h20];
    case (a)
      8'h00: return 8'hAD;
      8'h01: return 8'h1D;
      8'h02: return 8'hF2;
      8'h03: return 8'h01;
      8'h08: return 8'(m_x >>> 4);
      8'h09: return 8'(m_y >>> 4);
      8'h0A: return 8'(m_z >>> 4);
      8'h0B: return 8'h01;
      8'h0E: return 8'(m_x);
      8'h0F: return 8'(m_x >>> 8);
      8'h10: return 8'(m_y);
      8'h11: return 8'(m_y >>> 8);
      8'h12: return 8'(m_z);
      8'h13: return 8'(m_z >>> 8);
      default: return 8'h00;
    endcase
  endfunction

  function automatic void m_write(u8 a, u8 d);
`ifdef ACCEL_RESP_SOFT_RESET_EN
    if (a == 8'h1F && d == 8'h52) begin
      m_reset();
      return;
    end
`endif
    if (a >= 8'h20 && a <= 8'h2E) m_rw[a - 8'h20] = d;
  endfunction

  task automatic model(input u8 tx[$], input int nfull,
                       output u8 rx[$], output u16 wr[$],
                       output int ce);
    u8 ptr;
    ce  = 0;
    ptr = 8'h00;
    rx.delete();
    wr.delete();
    m_x = int'($signed(accel_x_i));
    m_y = int'($signed(accel_y_i));
    m_z = int'($signed(accel_z_i));
    for (int i = 0; i < nfull; i++) begin
      if (i == 0) begin
        rx.push_back(8'h00);
        if (tx[0] != 8'h0A && tx[0] != 8'h0B) ce = 1;
      end else if (ce != 0) begin
        rx.push_back(8'h00);
      end else if (i == 1) begin
        ptr = tx[1];
        rx.push_back(8'h00);
      end else if (tx[0] == 8'h0B) begin
        rx.push_back(m_read(ptr));
        ptr++;
      end else begin
        rx.push_back(8'h00);
        wr.push_back({ptr, tx[i]});
        m_write(ptr, tx[i]);
        ptr++;
      end
    end
  endtask

  task automatic send_byte(input u8 t, output u8 r);
    r = 8'h00;
    for (int b = 7; b >= 0; b--) begin
      mosi_i = t[b];
      #HALF;
      r = {r[6:0], miso_o};
      sclk_i = 1'b1;
      #HALF;
      sclk_i = 1'b0;
    end
  endtask

  task automatic run(string tag, input u8 tx[$],
                     input int nfull, input int pbits,
                     input bit chg, output u8 last);
    u8  rx_exp[$];
    u16 wr_exp[$];
    int ce_exp;
    u8  r;
    model(tx, nfull, rx_exp, wr_exp, ce_exp);
    wr_obs.delete();
    ce_obs = 0;
    last   = 8'h00;
    ss_i   = 1'b0;
    #(2*HALF);
    for (int i = 0; i < nfull; i++) begin
      send_byte(tx[i], r);
      check({tag, "_rx"}, 32'(r), 32'(rx_exp[i]));
      last = r;
      if (i == 0) check({tag, "_busy"}, 32'(busy_o), 1);
      if (chg && i == 2) accel_x_i = 12'($urandom);
    end
    for (int b = 0; b < pbits; b++) begin
      mosi_i = tx[nfull][7-b];
      #HALF;
      sclk_i = 1'b1;
      #HALF;
      sclk_i = 1'b0;
    end
    #HALF;
    ss_i = 1'b1;
    #(2*HALF);
    check({tag, "_miso_idle"}, 32'(miso_o), 0);
    check({tag, "_busy_idle"}, 32'(busy_o), 0);
    check({tag, "_cmderr"}, 32'(ce_obs), 32'(ce_exp));
    check({tag, "_nwr"}, 32'(wr_obs.size()),
          32'(wr_exp.size()));
    for (int i = 0; i < wr_exp.size(); i++) begin
      if (i < wr_obs.size())
        check({tag, "_wr"}, 32'(wr_obs[i]), 32'(wr_exp[i]));
    end
  endtask

  initial begin
    u8  tx[$];
    u8  last;
    u8  r;
    int n, pb;
    u8  cmd, addr;
    u8  addrs[10];

    reset_i   = 1'b1;
    ss_i      = 1'b1;
    sclk_i    = 1'b0;
    mosi_i    = 1'b0;
    accel_x_i = '0;
    accel_y_i = '0;
    accel_z_i = '0;
    repeat (4) @(negedge clk);
    check("rst_miso", 32'(miso_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_cmderr", 32'(cmd_err_o), 0);
    check("rst_wrp", 32'(wr_pulse_o), 0);
    check("rst_wra", 32'(wr_addr_o), 0);
    check("rst_wrd", 32'(wr_data_o), 0);
    reset_i = 1'b0;
    m_reset();
    repeat (10) @(negedge clk);
    #1;

    tx = {8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run("id", tx, 6, 0, 0, last);
    check("id_rev", 32'(last), 32'h01);

    accel_x_i = 12'hF85;
    tx = {8'h0B, 8'h0E, 8'h00, 8'h00};
    run("xlo", tx, 4, 0, 1, last);
    check("xhi", 32'(last), 32'hFF);

    tx = {8'h0A, 8'h2D, 8'h02};
    run("wr2d", tx, 3, 0, 0, last);
    tx = {8'h0B, 8'h2D, 8'h00};
    run("rd2d", tx, 3, 0, 0, last);
    check("rd2d_val", 32'(last), 32'h02);

    tx = {8'h0D, 8'h20, 8'h11, 8'h22};
    run("badcmd", tx, 4, 0, 0, last);

    tx = {8'h0A, 8'h2C, 8'h05};
    run("part", tx, 2, 5, 0, last);
    tx = {8'h0B, 8'h2C, 8'h00};
    run("part_rd", tx, 3, 0, 0, last);
    check("part_val", 32'(last), 32'h13);

    tx = {8'h0B, 8'hFF, 8'h00, 8'h00};
    run("wrap", tx, 4, 0, 0, last);
    check("wrap_val", 32'(last), 32'hAD);

    tx = {8'h0A, 8'h1F, 8'h52};
    run("soft", tx, 3, 0, 0, last);
    tx = {8'h0B, 8'h2D, 8'h00};
    run("soft_rd", tx, 3, 0, 0, last);
`ifdef ACCEL_RESP_SOFT_RESET_EN
    check("soft_val", 32'(last), 32'h00);
`else
    check("soft_val", 32'(last), 32'h02);
`endif

    tx = {8'h0A, 8'h20, 8'h77};
    run("pre", tx, 3, 0, 0, last);
    wr_obs.delete();
    ss_i = 1'b0;
    #(2*HALF);
    send_byte(8'h0A, r);
    @(negedge clk);
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    #1;
    send_byte(8'h21, r);
    send_byte(8'h55, r);
    #HALF;
    ss_i = 1'b1;
    #(2*HALF);
    check("rstmid_nowr", 32'(wr_obs.size()), 0);
    m_reset();
    tx = {8'h0B, 8'h20, 8'h00, 8'h00};
    run("rstmid_rd", tx, 4, 0, 0, last);

    addrs = '{8'h00, 8'h08, 8'h0E, 8'h10, 8'h12,
              8'h1F, 8'h20, 8'h2A, 8'h2E, 8'hFE};
    for (int t = 0; t < 24; t++) begin
      accel_x_i = 12'($urandom);
      accel_y_i = 12'($urandom);
      accel_z_i = 12'($urandom);
      n = $urandom_range(0, 9);
      cmd = (n < 4) ? 8'h0A : (n < 9) ? 8'h0B : 8'($urandom);
      addr = ($urandom_range(0, 3) == 0) ? 8'($urandom)
           : addrs[$urandom_range(0, 9)];
      tx = {cmd, addr};
      n = $urandom_range(0, 4);
      for (int k = 0; k < n + 1; k++)
        tx.push_back(($urandom_range(0, 3) == 0) ? 8'h52
                                                 : 8'($urandom));
      pb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      run("rnd", tx, 2 + n, pb, t[0], last);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/accel_spi_responder.md
ACCEL_SPI_RESPONDER -- requirements
Module: accel_spi_responder

Interface
REQ-001 Parameter SYNC_STAGES, 2, synchronizer depth on sclk/ss/mosi (legal 2..3).
REQ-002 Parameter REVID, 8'h01, value returned at register 0x03.
REQ-003 clk  input  1  system clock (100 MHz); sole clock of the block.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sclk  input  1  SPI serial clock from master, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-006 ss  input  1  SPI slave select, active low.
REQ-007 mosi  input  1  SPI master-out data, MSB first.
REQ-008 miso  output  1  SPI slave-out data, MSB first; driven 0 (no tristate) when not reading.
REQ-009 accel_x, accel_y, accel_z  input  12 each  signed two's-complement acceleration samples to report.
REQ-010 busy  output  1  high while synchronized ss is low.
REQ-011 cmd_err  output  1  one-clk pulse on unsupported command byte.
REQ-012 wr_pulse  output  1  one-clk pulse per committed register write; wr_addr output 8 and wr_data output 8 valid with it.

Function
REQ-013 sclk, ss, mosi SHALL pass through SYNC_STAGES flops; edges detected from last two synchronized samples; sclk half-period supported down to 4 clk cycles.
REQ-014 FSM states IDLE, CMD, ADDR, DATA, IGNORE; ss falling edge: IDLE->CMD; ss rising edge: any state->IDLE next cycle.
REQ-015 Bits sampled on synchronized sclk rising edge into 8-bit shift register; 3-bit counter; byte complete on 8th rising edge.
REQ-016 CMD byte 0x0A (write) or 0x0B (read) -> ADDR; any other value -> IGNORE plus cmd_err pulse.
REQ-017 ADDR byte loads 8-bit address pointer -> DATA.
REQ-018 DATA write: each completed byte written to pointer, wr_pulse/wr_addr/wr_data asserted same cycle, pointer +1.
REQ-019 DATA read: register at pointer loaded to output shift register when ADDR (or previous DATA) byte completes; miso presents MSB within 3 clk of that completion, next bit within 3 clk after each sclk falling edge; pointer +1 per byte.
REQ-020 Pointer increment wraps 0xFF->0x00.
REQ-021 Register map: 0x00=0xAD, 0x01=0x1D, 0x02=0xF2, 0x03=REVID; 0x08/0x09/0x0A = bits [11:4] of x/y/z; 0x0B STATUS=0x01; 0x0E/0x0F=X low byte / {4 sign bits, x[11:8]}, 0x10/0x11 Y, 0x12/0x13 Z same format; 0x20-0x2E read/write; all other addresses read 0x00.
REQ-022 Writes to read-only or unimplemented addresses SHALL be ignored in storage but still pulse wr_pulse.
REQ-023 accel_x/y/z SHALL be captured into shadow registers on the ss falling-edge cycle and held for the whole transaction (coherent burst).
REQ-024 ss rising edge with partial byte: partial byte discarded, no write, no pointer change; miso=0 within 1 clk.
REQ-025 sclk edges while ss high SHALL be ignored; IGNORE state ignores all sclk activity until ss high.

Reset
REQ-026 On reset: FSM=IDLE, counters/pointer=0, miso=0, busy=0, cmd_err=0, wr_pulse=0, wr_addr=0, wr_data=0, shadows=0.
REQ-027 On reset: 0x20-0x2E=0x00 except 0x2C=0x13; reset mid-transaction aborts it; traffic resumes only after next ss falling edge.

Configuration
REQ-028 Macro ACCEL_RESP_SOFT_RESET_EN defined: write of 0x52 to address 0x1F restores 0x20-0x2E to reset values at end of that byte; wr_pulse still asserted.
REQ-029 Macro undefined: 0x1F is plain unimplemented; 0x52 write has no effect on register contents.

Verification
REQ-030 After reset, read 0x0B,0x00 burst of 4 bytes -> miso returns 0xAD,0x1D,0xF2,0x01.
REQ-031 accel_x=12'hF85, read 0x0B,0x0E 2 bytes -> 0x85,0xFF; accel_x changed mid-burst -> values unchanged.
REQ-032 Write 0x0A,0x2D,0x02 then read 0x0B,0x2D -> 0x02; wr_pulse once with wr_addr=0x2D, wr_data=0x02.
REQ-033 Command 0x0D -> cmd_err one pulse, miso stays 0, no writes for rest of transaction.
REQ-034 Write 0x0A,0x2C,0x5 then ss high after 5 bits -> no wr_pulse, 0x2C reads 0x13; read burst from 0xFF -> second byte from 0x00 (0xAD).
REQ-035 With ACCEL_RESP_SOFT_RESET_EN: write 0x2D=0x02, then 0x1F=0x52 -> 0x2D reads 0x00; without macro -> 0x02.
